dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
- Data-side memory subsystem for the pipelined RV32 core; consumes the core's memory-stage outputs (MemWrite, ALUResult as address, WriteData) and returns ReadData in the same cycle.
- Contains word-addressed data RAM, a memory-mapped UART transmitter with TX FIFO, a free-running 64-bit cycle counter, and a sticky test-done register.
- Sits directly downstream of the core's M stage, instantiated alongside it in the SoC top.

Parameters:
- DEPTH, 1024, data RAM depth in 32-bit words (power of two).
- MEMFILE, "", optional hex init file for RAM; empty means no init.
- FIFO_DEPTH, 8, UART TX FIFO entries (power of two, >=2).
- CLKS_PER_BIT, 868, clock cycles per UART bit (>=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  store strobe from core M stage.
- Addr  in  32  byte address (core ALUResult); Addr[1:0] ignored.
- WriteData  in  32  store data.
- ReadData  out  32  load data, combinational from Addr.
- Tx  out  1  UART serial output, idle high.
- Done  out  1  sticky test-complete flag.
- DoneCode  out  32  value written with the DONE store.

Behaviour:
- Decode: Addr[31:28]==4'h0 -> RAM; 4'h1 -> MMIO; otherwise unmapped (reads 0, writes ignored).
- RAM: index Addr[log2(DEPTH)+1:2]; higher bits in region ignored (aliasing). Asynchronous read. Write on edge when MemWrite. Contents not reset.
- MMIO map (word offsets from 0x1000_0000):
  - 0x00 UART_TX: W pushes WriteData[7:0]; R returns 0.
  - 0x04 UART_STATUS: R {29'b0, busy, empty, full}; W ignored.
  - 0x08 CYCLE_LO, 0x0C CYCLE_HI: R counter halves; W ignored. No snapshot; software rereads HI for atomicity.
  - 0x10 DONE: W sets Done=1, DoneCode=WriteData on that edge; sticky until reset. Later DONE writes update DoneCode. R returns DoneCode.
  - Other MMIO offsets: read 0, write ignored.
- Cycle counter: 64-bit, +1 every cycle, wraps to 0, reset to 0. The value read in cycle k after reset deassertion is k.
- FIFO: push accepted iff !full || pop same cycle; otherwise byte silently dropped. Pop only by the TX engine. Pointers wrap modulo FIFO_DEPTH; full/empty from an occupancy count.
- TX engine states: IDLE, START, DATA, STOP.
  - IDLE & !empty: pop at edge, load shift reg, -> START.
  - START: Tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles, bit counter 0..7 -> STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles -> IDLE.
  - At least one IDLE cycle between frames.
  - busy = (state != IDLE). Tx is registered.
- Latency: a byte pushed at edge E0 into an empty FIFO with the engine IDLE is popped at E1. Tx falls after E1. The frame occupies 10*CLKS_PER_BIT cycles.
- Reset (any time, including mid-frame): Tx=1, Done=0, DoneCode=0, FIFO empty, state IDLE, counters 0, ReadData follows Addr decode. A partial frame is abandoned and queued bytes are lost.

Decomposition:
- Package dmem_mmio_pkg: region base constants, MMIO offset constants, status bit indices, TX state enum.
- One sub-module uart_tx (FIFO + baud counter + serializer); ports clk, reset, push, din[7:0], tx, full, empty, busy.
- RAM, decode, counter and DONE logic remain in dmem_mmio.

Test Plan:
- RAM: store 0xDEADBEEF to 0x100; same cycle after the edge, read 0x100 -> 0xDEADBEEF, 0x104 -> unchanged; read 0x100+DEPTH*4 -> 0xDEADBEEF (alias).
- UART frame, CLKS_PER_BIT=4: store 0x55 to 0x1000_0000 -> Tx low 4 cycles from the next edge, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4; busy=1 for 40 cycles; STATUS then reads 0x2.
- FIFO overflow, FIFO_DEPTH=8: 10 back-to-back TX stores of 0..9 -> byte 0 transmits, 1..8 queued, 9 dropped; STATUS reads 0x5; Tx sequence is exactly bytes 0..8.
- Counter: read 0x1000_0008 on cycles 0, 5, 100 after reset deassertion -> 0, 5, 100; CYCLE_HI reads 0; unmapped 0x2000_0000 reads 0.
- DONE: store 0x1 to 0x1000_0010 -> Done=1, DoneCode=1 after the edge; further cycles keep Done=1; reset -> both 0.
- Reset mid-frame: assert reset during DATA bit 3 with 3 bytes queued -> Tx=1 after the edge, STATUS=0x2, no further frames.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the data-side memory / MMIO subsystem.
// Region bases, MMIO word offsets, UART status bit positions and TX engine states.
package dmem_mmio_pkg;

   localparam logic [3:0] REGION_RAM  = 4'h0;
   localparam logic [3:0] REGION_MMIO = 4'h1;

   localparam logic [27:0] OFF_UART_TX     = 28'h000_0000;
   localparam logic [27:0] OFF_UART_STATUS = 28'h000_0004;
   localparam logic [27:0] OFF_CYCLE_LO    = 28'h000_0008;
   localparam logic [27:0] OFF_CYCLE_HI    = 28'h000_000C;
   localparam logic [27:0] OFF_DONE        = 28'h000_0010;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with a down-counting baud timer.
//   state    | meaning
//   TX_IDLE  | line high, pops the FIFO head when one is waiting
//   TX_START | start bit (low) for one bit period
//   TX_DATA  | 8 data bits, LSB first
//   TX_STOP  | stop bit (high) for one bit period, then back to idle
module uart_tx
   import dmem_mmio_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   output logic       tx,
   output logic       full,
   output logic       empty,
   output logic       busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   logic [7:0]    fifo [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          pop, push_ok;

   tx_state_t     state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic          tx_q, tx_n;

   assign full    = (count == (PW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   // A full FIFO still takes a byte when the engine frees a slot on the same edge.
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= TX_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
         tx_q    <= tx_n;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud;
      bit_n   = bit_idx;
      shift_n = shift;
      tx_n    = tx_q;
      pop     = 1'b0;
      case (state)
         TX_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_n = fifo[rd_ptr];
               tx_n    = 1'b0;
               baud_n  = BAUD_LAST;
               state_n = TX_START;
            end
         end
         TX_START: begin
            if (baud == '0) begin
               state_n = TX_DATA;
               tx_n    = shift[0];
               bit_n   = 3'd0;
               baud_n  = BAUD_LAST;
            end else begin
               baud_n = baud - 1'b1;
            end
         end
         TX_DATA: begin
            if (baud == '0) begin
               baud_n = BAUD_LAST;
               if (bit_idx == 3'd7) begin
                  state_n = TX_STOP;
                  tx_n    = 1'b1;
               end else begin
                  shift_n = {1'b0, shift[7:1]};
                  tx_n    = shift[1];
                  bit_n   = bit_idx + 3'd1;
               end
            end else begin
               baud_n = baud - 1'b1;
            end
         end
         TX_STOP: begin
            if (baud == '0)
               state_n = TX_IDLE;
            else
               baud_n = baud - 1'b1;
         end
         default: state_n = TX_IDLE;
      endcase
   end

   assign tx   = tx_q;
   assign busy = (state != TX_IDLE);

endmodule

// File: rtl/dmem_mmio.sv
// Data memory and MMIO block behind the core's M stage: RAM, UART TX, cycle counter, DONE.
// Loads are combinational from Addr; every state update happens on the rising edge.
module dmem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int DEPTH        = 1024,
   parameter     MEMFILE      = "",
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Tx,
   output logic        Done,
   output logic [31:0] DoneCode
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   ram [DEPTH];
   logic [AW-1:0] ram_idx;
   logic          is_ram, is_mmio;
   logic [27:0]   off;
   logic          uart_push, done_wr;
   logic          uart_full, uart_empty, uart_busy;
   logic [63:0]   cycle_cnt;
   logic          unused_addr;

   assign is_ram      = (Addr[31:28] == REGION_RAM);
   assign is_mmio     = (Addr[31:28] == REGION_MMIO);
   assign off         = {Addr[27:2], 2'b00};
   assign ram_idx     = Addr[AW+1:2];
   assign unused_addr = ^Addr[1:0];

   assign uart_push = MemWrite && is_mmio && (off == OFF_UART_TX);
   assign done_wr   = MemWrite && is_mmio && (off == OFF_DONE);

   always_ff @(posedge clk) begin
      if (MemWrite && is_ram)
         ram[ram_idx] <= WriteData;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= '0;
         Done      <= 1'b0;
         DoneCode  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (done_wr) begin
            Done     <= 1'b1;
            DoneCode <= WriteData;
         end
      end
   end

   uart_tx #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk   (clk),
      .reset (reset),
      .push  (uart_push),
      .din   (WriteData[7:0]),
      .tx    (Tx),
      .full  (uart_full),
      .empty (uart_empty),
      .busy  (uart_busy)
   );

   always_comb begin
      ReadData = '0;
      if (is_ram) begin
         ReadData = ram[ram_idx];
      end else if (is_mmio) begin
         case (off)
            OFF_UART_STATUS: begin
               ReadData[STAT_BUSY]  = uart_busy;
               ReadData[STAT_EMPTY] = uart_empty;
               ReadData[STAT_FULL]  = uart_full;
            end
            OFF_CYCLE_LO: ReadData = cycle_cnt[31:0];
            OFF_CYCLE_HI: ReadData = cycle_cnt[63:32];
            OFF_DONE:     ReadData = DoneCode;
            default:      ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, counter, DONE, UART framing, FIFO overflow, mid-frame reset.
module tb_dmem_mmio;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        tx;
   logic        done;
   logic [31:0] done_code;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rxq [$];
   int         fr_err = 0;
   logic       mon_en = 1'b0;

   dmem_mmio #(
      .DEPTH        (1024),
      .MEMFILE      (""),
      .FIFO_DEPTH   (8),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (mem_write),
      .Addr      (addr),
      .WriteData (write_data),
      .ReadData  (read_data),
      .Tx        (tx),
      .Done      (done),
      .DoneCode  (done_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr       = a;
      write_data = d;
      mem_write  = 1'b1;
      tick();
      mem_write  = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = read_data;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   // Serial receiver sampling mid-bit on the falling edge.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && tx === 1'b0) begin
            repeat (CPB/2) @(negedge clk);
            for (int d = 0; d < 8; d++) begin
               repeat (CPB) @(negedge clk);
               b[d] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) fr_err++;
            rxq.push_back(b);
         end
      end
   end

   initial begin
      logic [31:0] v;
      logic [31:0] exp_bit;
      logic [7:0]  pat;
      bit          ok;
      bit          low_seen;

      do_reset();
      mon_en = 1'b1;
      rd(32'h1000_0008, v);  check("cycle_k0", v, 32'd0);
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_donecode", done_code, 32'd0);
      rd(32'h1000_0004, v);  check("rst_status", v, 32'h2);
      repeat (5) tick();
      rd(32'h1000_0008, v);  check("cycle_k5", v, 32'd5);
      repeat (95) tick();
      rd(32'h1000_0008, v);  check("cycle_k100", v, 32'd100);
      rd(32'h1000_000C, v);  check("cycle_hi", v, 32'd0);
      rd(32'h2000_0000, v);  check("unmapped_rd", v, 32'd0);
      rd(32'h1000_0000, v);  check("uart_tx_rd", v, 32'd0);
      rd(32'h1000_0020, v);  check("mmio_other_rd", v, 32'd0);

      wr(32'h0000_0104, 32'h1234_5678);
      wr(32'h0000_0100, 32'hDEAD_BEEF);
      rd(32'h0000_0100, v);  check("ram_rd", v, 32'hDEAD_BEEF);
      rd(32'h0000_0104, v);  check("ram_neighbor", v, 32'h1234_5678);
      rd(32'h0000_1100, v);  check("ram_alias", v, 32'hDEAD_BEEF);
      wr(32'h2000_0100, 32'h0BAD_0BAD);
      rd(32'h0000_0100, v);  check("unmapped_wr", v, 32'hDEAD_BEEF);

      wr(32'h1000_0010, 32'h0000_0001);
      check("done_set", {31'b0, done}, 32'd1);
      check("donecode_set", done_code, 32'd1);
      rd(32'h1000_0010, v);  check("done_rd", v, 32'd1);
      wr(32'h1000_0010, 32'h0000_CAFE);
      check("donecode_upd", done_code, 32'h0000_CAFE);
      repeat (3) tick();
      check("done_sticky", {31'b0, done}, 32'd1);
      do_reset();
      check("done_rst", {31'b0, done}, 32'd0);
      check("donecode_rst", done_code, 32'd0);

      // Single frame of 0x55: start, 1010_1010 on the wire, stop.
      pat = 8'h55;
      wr(32'h1000_0000, {24'b0, pat});
      tick();
      for (int i = 0; i < 10*CPB; i++) begin
         if (i < CPB)          exp_bit = 32'd0;
         else if (i >= 9*CPB)  exp_bit = 32'd1;
         else                  exp_bit = {31'b0, pat[i/CPB - 1]};
         check("frame_tx", {31'b0, tx}, exp_bit);
         rd(32'h1000_0004, v);
         check("frame_busy", {31'b0, v[2]}, 32'd1);
         tick();
      end
      rd(32'h1000_0004, v);  check("frame_status_end", v, 32'h2);
      check("frame_tx_idle", {31'b0, tx}, 32'd1);

      // Ten back-to-back pushes: byte 0 leaves at once, 1..8 fill the FIFO, 9 drops.
      rxq.delete();
      fr_err = 0;
      for (int i = 0; i < 10; i++) wr(32'h1000_0000, i);
      rd(32'h1000_0004, v);  check("ovf_status", v, 32'h5);
      ok = 1'b0;
      for (int c = 0; c < 800 && !ok; c++) begin
         rd(32'h1000_0004, v);
         if (v == 32'h2 && rxq.size() >= 9) ok = 1'b1;
         else tick();
      end
      check("ovf_drain", {31'b0, ok}, 32'd1);
      check("ovf_count", rxq.size(), 32'd9);
      for (int i = 0; i < 9; i++)
         if (i < rxq.size()) check("ovf_byte", {24'b0, rxq[i]}, i);
      check("ovf_framing", fr_err, 32'd0);

      // Reset during DATA bit 3 with three bytes still queued.
      for (int i = 0; i < 4; i++) wr(32'h1000_0000, 32'hA0 + i);
      repeat (15) tick();
      rd(32'h1000_0004, v);  check("mid_status_pre", v, 32'h4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_tx_rst", {31'b0, tx}, 32'd1);
      rd(32'h1000_0004, v);  check("mid_status_rst", v, 32'h2);
      low_seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (tx !== 1'b1) low_seen = 1'b1;
      end
      check("mid_no_frames", {31'b0, low_seen}, 32'd0);
      rd(32'h1000_0004, v);  check("mid_status_after", v, 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
